// File: rtl/priority_decoder_if.sv
// rtl/priority_decoder_if.sv - code-in / mask-out handshake bundle for priority_decoder
interface priority_decoder_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_code;
    logic             mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_a;
    logic [7:0]       out_b;
    logic             out_none;
    logic             out_err;
    logic [CNT_W-1:0] dec_count;

    modport master (
        output in_valid, in_code, mode, flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_none, out_err, dec_count
    );

    modport slave (
        input  in_valid, in_code, mode, flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_none, out_err, dec_count
    );
endinterface

// File: rtl/priority_decoder.sv
// rtl/priority_decoder.sv - 4-bit index code to one-hot 16-bit mask decoder
// with single-word pipeline and OR-accumulate modes.
module priority_decoder #(
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    priority_decoder_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [15:0]      acc_mask;
    logic             acc_err;
    logic [15:0]      out_mask_r;
    logic             out_none_r;
    logic             out_err_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] count_r;

    logic             code_is_idx;
    logic             code_is_none;
    logic             code_is_err;
    logic [15:0]      code_mask;
    logic             in_ready_c;
    logic             accept;
    logic             out_xfer;
    logic [15:0]      acc_mask_next;
    logic             acc_err_next;

    assign code_is_idx  = (bus.in_code[7:4] == 4'h0);
    assign code_is_none = (bus.in_code == 8'hF0);
    assign code_is_err  = !code_is_idx && !code_is_none;
    assign code_mask    = code_is_idx ? (16'h0001 << bus.in_code[3:0]) : 16'h0000;

    always_comb begin
        in_ready_c = 1'b0;
        case (state)
            // mode=1 in IDLE holds input off while the pipeline word drains
            ST_IDLE: in_ready_c = !bus.mode && (!out_valid_r || bus.out_ready);
            ST_ACC:  in_ready_c = 1'b1;
            default: in_ready_c = 1'b0;
        endcase
        if (rst) begin
            in_ready_c = 1'b0;
        end
    end

    assign accept        = bus.in_valid && in_ready_c;
    assign out_xfer      = out_valid_r && bus.out_ready;
    assign acc_mask_next = acc_mask | (accept ? code_mask : 16'h0000);
    assign acc_err_next  = acc_err | (accept && code_is_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc_mask    <= 16'h0000;
            acc_err     <= 1'b0;
            out_mask_r  <= 16'h0000;
            out_none_r  <= 1'b0;
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            count_r     <= '0;
        end else begin
            // A same-cycle index code survives the emit clear as a count of one
            if (out_xfer) begin
                count_r <= (accept && code_is_idx) ? CNT_W'(1) : '0;
            end else if (accept && code_is_idx && count_r != CNT_MAX) begin
                count_r <= count_r + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (!bus.mode) begin
                        if (accept) begin
                            out_mask_r  <= code_mask;
                            out_none_r  <= code_is_none;
                            out_err_r   <= code_is_err;
                            out_valid_r <= 1'b1;
                        end else if (out_xfer) begin
                            out_valid_r <= 1'b0;
                        end
                    end else if (!out_valid_r || bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_mask <= acc_mask_next;
                    acc_err  <= acc_err_next;
                    if (bus.flush) begin
                        out_mask_r  <= acc_mask_next;
                        out_none_r  <= (acc_mask_next == 16'h0000);
                        out_err_r   <= acc_err_next;
                        out_valid_r <= 1'b1;
                        state       <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        acc_mask    <= 16'h0000;
                        acc_err     <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_a     = out_mask_r[15:8];
    assign bus.out_b     = out_mask_r[7:0];
    assign bus.out_none  = out_none_r;
    assign bus.out_err   = out_err_r;
    assign bus.dec_count = count_r;
endmodule

// File: tb/tb_priority_decoder.sv
// tb/tb_priority_decoder.sv - randomized and directed checks of priority_decoder
// against a queue-based behavioural model.
module tb_priority_decoder;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    priority_decoder_if #(.CNT_W(CNT_W)) bus ();
    priority_decoder #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        bit [15:0] mask;
        bit        none;
        bit        err;
    } word_t;

    word_t q[$];
    bit    seen[16];
    bit    m_err     = 1'b0;
    bit    gathering = 1'b0;
    bit    emitting  = 1'b0;
    int    cnt       = 0;
    int    n_pass    = 0;
    int    n_total   = 0;
    logic  last_ready;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit model_ready(bit r, bit m, bit ordy);
        if (r) return 1'b0;
        if (gathering) return 1'b1;
        if (emitting) return 1'b0;
        return !m && (q.size() == 0 || ordy);
    endfunction

    task automatic model_step(bit r, bit iv, bit [7:0] code, bit m, bit fl, bit ordy);
        bit    rdy, acc, xfer, idx, was_empty;
        word_t w;
        rdy = model_ready(r, m, ordy);
        if (r) begin
            q.delete();
            foreach (seen[i]) seen[i] = 1'b0;
            m_err = 0; gathering = 0; emitting = 0; cnt = 0;
            return;
        end
        acc       = iv && rdy;
        idx       = (code < 16);
        xfer      = (q.size() > 0) && ordy;
        was_empty = (q.size() == 0);
        if (xfer) cnt = 0;
        if (acc && idx) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
        if (gathering) begin
            if (acc) begin
                if (idx) seen[code[3:0]] = 1'b1;
                else if (code != 8'hF0) m_err = 1'b1;
            end
            if (fl) begin
                w.mask = 16'h0;
                foreach (seen[i]) if (seen[i]) w.mask += 16'(1 << i);
                w.none = (w.mask == 16'h0);
                w.err  = m_err;
                q.push_back(w);
                gathering = 0;
                emitting  = 1;
            end
        end else if (emitting) begin
            if (xfer) begin
                void'(q.pop_front());
                emitting = 0;
                foreach (seen[i]) seen[i] = 1'b0;
                m_err = 0;
            end
        end else begin
            if (xfer) void'(q.pop_front());
            if (!m) begin
                if (acc) begin
                    w.mask = idx ? 16'(1 << code[3:0]) : 16'h0;
                    w.none = (code == 8'hF0);
                    w.err  = !idx && (code != 8'hF0);
                    q.push_back(w);
                end
            end else if (was_empty || xfer) begin
                gathering = 1;
            end
        end
    endtask

    task automatic cycle(bit r, bit iv, bit [7:0] code, bit m, bit fl, bit ordy);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_code   = code;
        bus.mode      = m;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        last_ready = bus.in_ready;
        check("in_ready", bus.in_ready, model_ready(r, m, ordy));
        model_step(r, iv, code, m, fl, ordy);
        @(posedge clk);
        #1;
        check("out_valid", bus.out_valid, q.size() > 0);
        check("dec_count", bus.dec_count, cnt);
        if (q.size() > 0) begin
            check("out_mask", {bus.out_a, bus.out_b}, q[0].mask);
            check("out_none", bus.out_none, q[0].none);
            check("out_err", bus.out_err, q[0].err);
        end
    endtask

    bit       r_r, m_r, iv_r, fl_r, ordy_r;
    bit [7:0] code_r;
    int       sel, c;

    initial begin
        foreach (seen[i]) seen[i] = 1'b0;
        cycle(1, 1, 8'h01, 0, 0, 1);
        check("rst_in_ready", last_ready, 0);
        cycle(1, 0, 8'h00, 0, 0, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_ab", {bus.out_a, bus.out_b}, 0);
        check("rst_none_err", {bus.out_none, bus.out_err}, 0);
        check("rst_count", bus.dec_count, 0);

        // single mode streaming
        cycle(0, 1, 8'h0F, 0, 0, 1);
        check("s1_ab", {bus.out_a, bus.out_b}, 16'h8000);
        cycle(0, 1, 8'h00, 0, 0, 1);
        check("s2_ab", {bus.out_a, bus.out_b}, 16'h0001);
        cycle(0, 1, 8'hF0, 0, 0, 1);
        check("s3_ab_none", {bus.out_a, bus.out_b, bus.out_none, bus.out_err}, {16'h0000, 2'b10});
        cycle(0, 1, 8'h3A, 0, 0, 1);
        check("s4_ab_err", {bus.out_a, bus.out_b, bus.out_none, bus.out_err}, {16'h0000, 2'b01});
        check("s4_valid", bus.out_valid, 1);
        cycle(0, 0, 8'h00, 0, 0, 1);
        check("s5_valid", bus.out_valid, 0);

        // backpressure holds the word
        cycle(0, 1, 8'h05, 0, 0, 0);
        check("bp1_ab", {bus.out_a, bus.out_b}, 16'h0020);
        cycle(0, 1, 8'h07, 0, 0, 0);
        check("bp2_ready", last_ready, 0);
        check("bp2_ab", {bus.out_a, bus.out_b}, 16'h0020);
        cycle(0, 1, 8'h07, 0, 0, 1);
        check("bp3_ab", {bus.out_a, bus.out_b}, 16'h0080);
        cycle(0, 0, 8'h00, 0, 0, 1);

        // accumulate with flush carrying a code
        cycle(0, 1, 8'h01, 1, 0, 0);
        check("acc_enter_ready", last_ready, 0);
        cycle(0, 1, 8'h01, 1, 0, 0);
        cycle(0, 1, 8'h09, 1, 0, 0);
        cycle(0, 1, 8'h01, 1, 0, 0);
        cycle(0, 1, 8'h0E, 1, 1, 0);
        check("acc1_ab", {bus.out_a, bus.out_b}, 16'h4202);
        check("acc1_flags", {bus.out_none, bus.out_err}, 2'b00);
        check("acc1_count", bus.dec_count, 4);
        cycle(0, 0, 8'h00, 0, 0, 1);

        // illegal and none codes only
        cycle(0, 0, 8'h00, 1, 0, 1);
        cycle(0, 1, 8'h20, 1, 0, 0);
        cycle(0, 1, 8'hF0, 1, 0, 0);
        cycle(0, 0, 8'h00, 1, 1, 0);
        check("acc2_ab", {bus.out_a, bus.out_b}, 16'h0000);
        check("acc2_flags", {bus.out_none, bus.out_err}, 2'b11);
        check("acc2_count", bus.dec_count, 0);
        cycle(0, 0, 8'h00, 0, 0, 1);

        // counter saturation
        cycle(0, 0, 8'h00, 1, 0, 1);
        for (int i = 0; i < 40; i++) cycle(0, 1, 8'h03, 1, 0, 0);
        cycle(0, 0, 8'h00, 1, 1, 0);
        check("sat_count", bus.dec_count, 31);
        check("sat_ab", {bus.out_a, bus.out_b}, 16'h0008);
        cycle(0, 0, 8'h00, 0, 0, 1);

        // reset mid-accumulation
        cycle(0, 0, 8'h00, 1, 0, 1);
        cycle(0, 1, 8'h02, 1, 0, 0);
        cycle(1, 1, 8'h02, 1, 1, 1);
        check("mid_rst_ready", last_ready, 0);
        check("mid_rst_valid", bus.out_valid, 0);
        cycle(0, 1, 8'h04, 0, 0, 1);
        check("post_rst_ab", {bus.out_a, bus.out_b}, 16'h0010);
        check("post_rst_valid", bus.out_valid, 1);
        cycle(0, 0, 8'h00, 0, 0, 1);

        m_r = 0;
        for (int i = 0; i < 3000; i++) begin
            r_r = ($urandom_range(99) == 0);
            if ($urandom_range(15) == 0) m_r = !m_r;
            iv_r = ($urandom_range(9) < 7);
            sel  = $urandom_range(19);
            if (sel < 12) code_r = 8'($urandom_range(15));
            else if (sel < 15) code_r = 8'hF0;
            else begin
                c = $urandom_range(255);
                if (c < 16 || c == 8'hF0) c = 8'h3A;
                code_r = 8'(c);
            end
            fl_r   = ($urandom_range(9) < 2);
            ordy_r = ($urandom_range(9) < 6);
            cycle(r_r, iv_r, code_r, m_r, fl_r, ordy_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 Parameter: CNT_W, default 5, width of dec_count.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_code valid this cycle.
REQ-005 in_ready  output  1  block accepts in_code this cycle.
REQ-006 in_code  input  8  code word: 0x00-0x0F = bit index, 0xF0 = none, any other value = illegal.
REQ-007 mode  input  1  0 = single (one code per output), 1 = accumulate (OR codes into one mask).
REQ-008 flush  input  1  end of accumulation; used only in ACC.
REQ-009 out_valid  output  1  output word valid.
REQ-010 out_ready  input  1  consumer takes the output word this cycle.
REQ-011 out_a  output  8  decoded mask bits 15..8.
REQ-012 out_b  output  8  decoded mask bits 7..0.
REQ-013 out_none  output  1  output mask is all-zero by a 0xF0 code or an empty accumulation.
REQ-014 out_err  output  1  an illegal code contributed to this output word.
REQ-015 dec_count  output  CNT_W  legal index codes accepted since the last emit or reset.

Function
REQ-016 A transfer SHALL occur on any cycle where valid and ready are both high, on either port.
REQ-017 Decode of code k (0..15) SHALL set bit k of the 16-bit mask {out_a,out_b} only.
REQ-018 Decode of 0xF0 SHALL give mask 0 with out_none=1 and out_err=0.
REQ-019 Decode of an illegal code SHALL give mask 0 with out_err=1 and out_none=0.
REQ-020 The FSM SHALL have three states: IDLE, ACC and EMIT.
REQ-021 In IDLE with mode=0, the output register SHALL be a one-entry pipeline stage with in_ready = !out_valid || out_ready.
REQ-022 In IDLE with mode=0, an accepted code SHALL appear on the outputs with out_valid=1 the next cycle, giving 1-cycle latency.
REQ-023 In IDLE, out_valid SHALL stay high and the outputs SHALL stay stable until out_ready=1.
REQ-024 Back-to-back transfers in IDLE with mode=0 SHALL sustain one word per cycle when out_ready is held high.
REQ-025 IDLE->ACC SHALL occur when mode=1 and the output register is empty or draining this cycle.
REQ-026 in_ready SHALL be 0 during the IDLE cycle that takes the IDLE->ACC transition.
REQ-027 mode SHALL be sampled only in IDLE; changes to mode in ACC or EMIT SHALL be ignored.
REQ-028 In ACC: in_ready=1 and out_valid=0.
REQ-029 In ACC, each accepted index code SHALL OR its bit into the internal mask.
REQ-030 In ACC, an accepted illegal code SHALL set a sticky err flag without changing the mask.
REQ-031 In ACC, an accepted 0xF0 code SHALL change neither the mask nor the err flag.
REQ-032 ACC->EMIT SHALL occur on flush=1; a code accepted in the same cycle as flush SHALL be included in the emitted word.
REQ-033 In EMIT: in_ready=0 and out_valid=1.
REQ-034 In EMIT, the outputs SHALL be the mask, out_err = sticky err flag, and out_none = (mask==0).
REQ-035 EMIT->IDLE SHALL occur on out_ready=1; the mask and err flag SHALL clear on the same edge.
REQ-036 dec_count SHALL increment on each accepted index code in any state and saturate at 2^CNT_W-1.
REQ-037 dec_count SHALL clear on each output transfer; a code accepted in the same cycle counts as 1 after the clear.
REQ-038 Re-accepting an index code already set in the mask SHALL leave the mask unchanged and SHALL still count.
REQ-039 flush SHALL be ignored in IDLE and EMIT.

Reset
REQ-040 On rst=1 at a clock edge: state=IDLE, out_valid=0, out_a=0, out_b=0, out_none=0, out_err=0, dec_count=0, mask=0, err flag=0.
REQ-041 With rst=1, in_ready SHALL be 0.
REQ-042 rst=1 in any state, including mid-accumulation or EMIT, SHALL discard pending data with no output transfer.
REQ-043 Reset SHALL take priority over every simultaneous input event.

Verification
REQ-044 mode=0, out_ready=1, codes 0x0F,0x00,0xF0,0x3A on consecutive cycles -> next cycles {a,b}=0x8000, 0x0001, 0x0000 with none=1, 0x0000 with err=1; out_valid high 4 cycles.
REQ-045 mode=0, out_ready=0, send 0x05 then hold 0x07 -> out_valid=1, {a,b}=0x0020 stable and in_ready=0; raise out_ready -> 0x0080 next cycle.
REQ-046 mode=1, codes 0x01,0x09,0x01, then flush together with 0x0E -> EMIT {a,b}=0x4202, none=0, err=0, dec_count=4.
REQ-047 mode=1, codes 0x20 then 0xF0, flush -> {a,b}=0x0000, err=1, none=1, dec_count=0.
REQ-048 mode=1, 40 codes of 0x03 then flush -> dec_count saturates at 31, {a,b}=0x0008.
REQ-049 rst=1 asserted in ACC after 0x02, then mode=0 and code 0x04 -> next word {a,b}=0x0010; no stale 0x0004 appears.
